// File: rtl/complex_if_main.sv
// complex_if_main: four-state fetch/compute block reading a 2-entry control array; registered-strobe variant (w_enable high the cycle after edge N+3).
module complex_if_main (
  input  logic       clk,
  input  logic       reset,
  input  logic       r_enable,
  input  logic       init_i,
  output logic       controlArrAddr_a,
  input  logic       controlArrRData_a,
  output logic       controlArrWData_a,
  output logic       controlArrWEnable_a,
  output logic       w_enable,
  output logic [1:0] result
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;
  state_t state, state_next;
  logic idx;
  assign controlArrAddr_a = idx;
  assign controlArrWData_a = 1'b0;
  assign controlArrWEnable_a = 1'b0;
  always_comb begin
    state_next = state;
    state_next = state == IDLE  ? (r_enable ? FETCH : IDLE) :
                 state == FETCH ? WAIT :
                 state == WAIT  ? DONE : IDLE;
  end
  // result table {idx,c} -> 1,2,3,0 is (1 + c + 2*idx) mod 4
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= 1'b0;
      result <= 2'd0;
      w_enable <= 1'b0;
    end else begin
      state <= state_next;
      w_enable <= state == DONE;
      if (state == IDLE && r_enable) idx <= init_i;
      if (state == WAIT) result <= 2'd1 + {1'b0, controlArrRData_a} + {idx, 1'b0};
    end
  end
endmodule

// File: tb/tb_complex_if_main.sv
// tb_complex_if_main: transaction-timeline model plus directed scenarios for complex_if_main.
module tb_complex_if_main;
  logic clk = 0, reset = 1, r_enable = 0, init_i = 0;
  logic addr, rdata = 0, wdata, wen, w_enable;
  logic [1:0] result;
  logic arr [2] = '{1'b0, 1'b0};
  logic [1:0] res_tab [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  int errors = 0, checks = 0, cyc = 0, t_start = -1, pulses = 0, p0;
  logic m_idx = 0, exp_w = 0, armed = 0;
  logic [1:0] exp_res = 0;

  complex_if_main dut (
    .clk(clk), .reset(reset), .r_enable(r_enable), .init_i(init_i),
    .controlArrAddr_a(addr), .controlArrRData_a(rdata),
    .controlArrWData_a(wdata), .controlArrWEnable_a(wen),
    .w_enable(w_enable), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rdata <= arr[addr];
  always @(posedge clk) if (w_enable) pulses++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // A request accepted at edge N yields result at edge N+2 and a strobe after edge N+3
  always @(posedge clk) begin
    if (reset) begin
      t_start = -1; m_idx = 0; exp_w = 0; exp_res = 0; armed = 1;
    end else begin
      if (t_start < 0 && r_enable) begin t_start = cyc; m_idx = init_i; end
      exp_w = t_start >= 0 && cyc == t_start + 3;
      if (t_start >= 0 && cyc == t_start + 2) exp_res = res_tab[{m_idx, arr[m_idx]}];
      if (exp_w) t_start = -1;
    end
    cyc++;
  end

  always @(negedge clk) if (armed) begin
    check("w_enable", int'(w_enable), int'(exp_w));
    check("result", int'(result), int'(exp_res));
    check("addr", int'(addr), int'(m_idx));
    check("wdata", int'(wdata), 0);
    check("wen", int'(wen), 0);
  end

  task automatic txn(input logic i, input logic a, input logic [1:0] exp);
    arr[i] = a; init_i = i; r_enable = 1; p0 = pulses;
    @(negedge clk);
    r_enable = 0; init_i = ~i;
    repeat (5) @(negedge clk);
    check("txn_result", int'(result), int'(exp));
    check("txn_pulses", pulses - p0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_w", int'(w_enable), 0);
    check("rst_result", int'(result), 0);
    check("rst_addr", int'(addr), 0);
    reset = 0;
    @(negedge clk);
    txn(0, 0, 2'd1);
    txn(0, 1, 2'd2);
    txn(1, 0, 2'd3);
    txn(1, 1, 2'd0);
    // re-requests during FETCH and WAIT are dropped
    arr[1] = 0; init_i = 1; r_enable = 1; p0 = pulses;
    repeat (3) @(negedge clk);
    r_enable = 0;
    repeat (6) @(negedge clk);
    check("ignore_pulses", pulses - p0, 1);
    check("ignore_result", int'(result), 3);
    // reset in WAIT aborts the transaction
    arr[0] = 1; init_i = 0; r_enable = 1; p0 = pulses;
    @(negedge clk);
    r_enable = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("abort_result", int'(result), 0);
    repeat (4) @(negedge clk);
    check("abort_pulses", pulses - p0, 0);
    txn(0, 1, 2'd2);
    // continuous request: starts every 4 cycles
    arr[1] = 0; init_i = 1; r_enable = 1; p0 = pulses;
    repeat (12) @(negedge clk);
    r_enable = 0;
    repeat (6) @(negedge clk);
    check("stream_pulses", pulses - p0, 3);
    check("stream_result", int'(result), 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
